// File: rtl/booth4_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth4_pkg;

  // Controller states of the sequential multiplier.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } booth_state_e;

  // Partial-product selection produced by the Booth recoder.
  typedef enum logic [2:0] {
    ZERO,
    PM,
    P2M,
    NM,
    N2M
  } booth_op_e;

  // Number of radix-4 steps needed to consume a (width+2)-bit extended multiplier.
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth4_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window (two bits plus the
// look-bit below them) to the partial product to accumulate.
module booth4_recoder
  import booth4_pkg::*;
(
  input  logic [2:0] bits_i,
  output booth_op_e  op_o
);

  // Standard Booth table; 000 and 111 contribute nothing.
  always_comb begin
    op_o = ZERO;
    case (bits_i)
      3'b001, 3'b010: op_o = PM;
      3'b011:         op_o = P2M;
      3'b100:         op_o = N2M;
      3'b101, 3'b110: op_o = NM;
      default:        op_o = ZERO;
    endcase
  end

endmodule

// File: rtl/booth4_multiplier_seq.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per clock.
// Produces the exact 2*WIDTH product for signed or unsigned operands, with a
// truncation flag for the low half, a busy flag and a one-cycle ready pulse.
// A new start during a run aborts it and reloads; reset takes priority.
// Optional: define BOOTH4_EARLY_EXIT_EN to finish as soon as the remaining
// multiplier bits are all equal (all further recodes would be zero).
module booth4_multiplier_seq
  import booth4_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int ITER = iter_count(WIDTH);
  localparam int CW   = $clog2(ITER + 1);
  localparam int AW   = WIDTH + 4;      // accumulator
  localparam int MW   = WIDTH + 3;      // extended multiplier plus look-bit
  localparam int PW   = AW + MW;        // shifted {accumulator, multiplier} pair

  booth_state_e     state_q;
  logic [WIDTH+1:0] mcand_q;
  logic [MW-1:0]    mplier_q;
  logic [AW-1:0]    acc_q;
  logic [CW-1:0]    count_q;
  logic             signed_q;

  booth_op_e        op;
  logic [AW-1:0]    m_sext;
  logic [AW-1:0]    addend;
  logic             carry_in;
  logic [AW-1:0]    acc_sum;
  logic [PW-1:0]    step_pair;
  logic [PW-1:0]    final_pair;
  logic             last_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0] prod_hi_d;
  logic [WIDTH-1:0] prod_lo_d;
  logic             exc_d;
  logic             unused_pair_bits;

  booth4_recoder u_recoder (
    .bits_i (mplier_q[2:0]),
    .op_o   (op)
  );

  // Select the partial product; negation is inversion plus a carry-in.
  always_comb begin
    m_sext   = {{2{mcand_q[WIDTH+1]}}, mcand_q};
    addend   = '0;
    carry_in = 1'b0;
    case (op)
      PM:  addend = m_sext;
      P2M: addend = {m_sext[AW-2:0], 1'b0};
      NM: begin
        addend   = ~m_sext;
        carry_in = 1'b1;
      end
      N2M: begin
        addend   = ~{m_sext[AW-2:0], 1'b0};
        carry_in = 1'b1;
      end
      default: addend = '0;
    endcase
    acc_sum = acc_q + addend + {{(AW-1){1'b0}}, carry_in};
  end

  assign step_pair = $signed({acc_sum, mplier_q}) >>> 2;

`ifdef BOOTH4_EARLY_EXIT_EN
  // Arithmetic-shifted copy of the multiplier: its low bits are the bits not
  // yet consumed and its upper bits replicate their sign, so "remaining bits
  // all equal" is simply all-zeros or all-ones.
  logic [MW-1:0] brem_q;
  logic          early_exit;
  logic [CW:0]   shamt;
  logic [PW-1:0] exit_pair;

  assign early_exit = (&brem_q) | ~(|brem_q);
  assign shamt      = (CW+1)'(2 * (ITER - int'(count_q)));
  assign exit_pair  = $signed({acc_q, mplier_q}) >>> shamt;
  assign final_pair = early_exit ? exit_pair : step_pair;
  assign last_d     = early_exit | (count_q == CW'(ITER - 1));

  // Track the unconsumed multiplier bits alongside the main datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      brem_q <= '0;
    end else if (ctrl_MULT) begin
      brem_q <= {{2{ctrl_signed & data_operandB[WIDTH-1]}}, data_operandB, 1'b0};
    end else if (state_q == RUN) begin
      brem_q <= $signed(brem_q) >>> 2;
    end
  end
`else
  assign final_pair = step_pair;
  assign last_d     = (count_q == CW'(ITER - 1));
`endif

  // The pair holds the full extended product above the leftover look-bit.
  assign prod_d    = final_pair[2*WIDTH:1];
  assign prod_hi_d = prod_d[2*WIDTH-1:WIDTH];
  assign prod_lo_d = prod_d[WIDTH-1:0];
  assign exc_d     = signed_q ? (prod_hi_d != {WIDTH{prod_lo_d[WIDTH-1]}})
                              : (|prod_hi_d);
  assign unused_pair_bits = ^{final_pair[PW-1:2*WIDTH+1], final_pair[0]};

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      count_q        <= '0;
      signed_q       <= 1'b0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= '0;
      data_result_hi <= '0;
      data_exception <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        // Start from any state; an operation in flight is discarded.
        state_q  <= RUN;
        busy     <= 1'b1;
        mcand_q  <= {{2{ctrl_signed & data_operandA[WIDTH-1]}}, data_operandA};
        mplier_q <= {{2{ctrl_signed & data_operandB[WIDTH-1]}}, data_operandB, 1'b0};
        acc_q    <= '0;
        count_q  <= '0;
        signed_q <= ctrl_signed;
      end else begin
        case (state_q)
          RUN: begin
            acc_q    <= final_pair[PW-1:MW];
            mplier_q <= final_pair[MW-1:0];
            count_q  <= count_q + 1'b1;
            if (last_d) begin
              state_q        <= DONE;
              busy           <= 1'b0;
              data_resultRDY <= 1'b1;
              data_result    <= prod_lo_d;
              data_result_hi <= prod_hi_d;
              data_exception <= exc_d;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth4_multiplier_seq.sv
// Self-checking bench for booth4_multiplier_seq (WIDTH=32 and WIDTH=8 instances).
module tb_booth4_multiplier_seq;

`ifdef BOOTH4_EARLY_EXIT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        mult = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [31:0] lo32, hi32;
  logic        exc32, rdy32, busy32;
  logic [7:0]  lo8, hi8;
  logic        exc8, rdy8, busy8;

  int n_cmp = 0;
  int n_bad = 0;

  booth4_multiplier_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .ctrl_MULT(mult), .ctrl_signed(sgn),
    .data_operandA(a32), .data_operandB(b32),
    .data_result(lo32), .data_result_hi(hi32), .data_exception(exc32),
    .data_resultRDY(rdy32), .busy(busy32)
  );

  booth4_multiplier_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .ctrl_MULT(mult), .ctrl_signed(sgn),
    .data_operandA(a8), .data_operandB(b8),
    .data_result(lo8), .data_result_hi(hi8), .data_exception(exc8),
    .data_resultRDY(rdy8), .busy(busy8)
  );

  typedef struct {
    bit          w8;
    logic [31:0] a, b;
    bit          s;
    logic [31:0] hi, lo;
    bit          exc;
  } vec_t;

  // Reference: exact integer product of the extended operands.
  function automatic void model(input bit w8, input logic [31:0] a, input logic [31:0] b,
                                input bit s, output logic [31:0] hi, output logic [31:0] lo,
                                output bit exc);
    int w;
    longint unsigned mask;
    longint ea, eb, p;
    w    = w8 ? 8 : 32;
    mask = (64'd1 << w) - 64'd1;
    ea = longint'({32'b0, a} & mask);
    eb = longint'({32'b0, b} & mask);
    if (s && a[w-1]) ea = ea | longint'(~mask);
    if (s && b[w-1]) eb = eb | longint'(~mask);
    p  = ea * eb;
    hi = 32'((p >>> w) & longint'(mask));
    lo = 32'(p & longint'(mask));
    exc = s ? (hi != (lo[w-1] ? 32'(mask) : 32'd0)) : (hi != 32'd0);
  endfunction

  // Expected edges from load to ready: fixed, or the step at which the
  // remaining multiplier bits (with look-bit) first become uniform.
  function automatic int exp_lat(input bit w8, input logic [31:0] b, input bit s);
    int w, iter;
    longint unsigned mask;
    longint eb, t;
    w    = w8 ? 8 : 32;
    iter = w / 2 + 1;
    mask = (64'd1 << w) - 64'd1;
    eb = longint'({32'b0, b} & mask);
    if (s && b[w-1]) eb = eb | longint'(~mask);
    eb = eb <<< 1;
    for (int k = 0; k < iter; k++) begin
      t = eb >>> (2 * k);
      if (EARLY_EN && (t == 0 || t == -1)) return k + 1;
    end
    return iter;
  endfunction

  function automatic logic [31:0] pick(input bit w8);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = w8 ? 32'h80 : 32'h8000_0000;
      4: v = w8 ? 32'h7F : 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    if (w8) v = v & 32'hFF;
    return v;
  endfunction

  // Drive one operation and measure it; comparisons are left to the caller.
  task automatic do_op(input bit w8, input logic [31:0] a, input logic [31:0] b, input bit s,
                       output int lat, output logic [31:0] hi, output logic [31:0] lo,
                       output bit exc, output bit busy_ok, output bit pulse_ok);
    lat = -1; hi = '0; lo = '0; exc = 1'b0; busy_ok = 1'b1; pulse_ok = 1'b0;
    @(negedge clock);
    mult = 1'b1; sgn = s; a32 = a; b32 = b; a8 = a[7:0]; b8 = b[7:0];
    @(posedge clock); #1;
    mult = 1'b0; sgn = 1'($urandom); a32 = $urandom; b32 = $urandom;
    a8 = 8'($urandom); b8 = 8'($urandom);
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (w8 ? rdy8 : rdy32) begin
        lat = n;
        hi  = w8 ? {24'b0, hi8} : hi32;
        lo  = w8 ? {24'b0, lo8} : lo32;
        exc = w8 ? exc8 : exc32;
        if (w8 ? busy8 : busy32) busy_ok = 1'b0;
        break;
      end
      if (!(w8 ? busy8 : busy32)) busy_ok = 1'b0;
    end
    if (lat > 0) begin
      @(posedge clock); #1;
      pulse_ok = !(w8 ? rdy8 : rdy32);
    end
    $display("op w=%0d s=%0d a=%h b=%h -> hi=%h lo=%h exc=%0b lat=%0d",
             w8 ? 8 : 32, s, a, b, hi, lo, exc, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if ({busy32, rdy32, exc32} !== 3'b000) begin n_bad++;
      $display("FAIL reset_flags32 got busy/rdy/exc=%b expected 000", {busy32, rdy32, exc32}); end
    n_cmp++; if ({hi32, lo32} !== 64'd0) begin n_bad++;
      $display("FAIL reset_result32 got %h expected 0", {hi32, lo32}); end
    n_cmp++; if ({busy8, rdy8, exc8, hi8, lo8} !== 19'd0) begin n_bad++;
      $display("FAIL reset_w8 got %h expected 0", {busy8, rdy8, exc8, hi8, lo8}); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[7];
    int lat; logic [31:0] hi, lo; bit exc, bok, pok;
    v[0] = '{1'b0, 32'hFFFF_FFF9, 32'd6,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
    v[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1};
    v[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0,         32'h1,         1'b0};
    v[3] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0,         32'h8000_0000, 1'b1};
    v[4] = '{1'b1, 32'h80,        32'h80,        1'b1, 32'h40,        32'h00,        1'b1};
    v[5] = '{1'b1, 32'hFF,        32'hFF,        1'b0, 32'hFE,        32'h01,        1'b1};
    v[6] = '{1'b1, 32'hFF,        32'hFF,        1'b1, 32'h00,        32'h01,        1'b0};
    foreach (v[i]) begin
      do_op(v[i].w8, v[i].a, v[i].b, v[i].s, lat, hi, lo, exc, bok, pok);
      n_cmp++; if ({hi, lo} !== {v[i].hi, v[i].lo}) begin n_bad++;
        $display("FAIL dir%0d_product got %h_%h expected %h_%h", i, hi, lo, v[i].hi, v[i].lo); end
      n_cmp++; if (exc !== v[i].exc) begin n_bad++;
        $display("FAIL dir%0d_exception got %0b expected %0b", i, exc, v[i].exc); end
      n_cmp++; if (lat != exp_lat(v[i].w8, v[i].b, v[i].s)) begin n_bad++;
        $display("FAIL dir%0d_latency got %0d expected %0d", i, lat, exp_lat(v[i].w8, v[i].b, v[i].s)); end
      n_cmp++; if (!(bok && pok)) begin n_bad++;
        $display("FAIL dir%0d_busy_pulse got busy_ok=%0b pulse_ok=%0b expected 1 1", i, bok, pok); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] a, b, hi, lo, ehi, elo; bit s, w8, exc, eexc, bok, pok;
    for (int i = 0; i < 60; i++) begin
      w8 = (i >= 40);
      a = pick(w8); b = pick(w8); s = 1'($urandom);
      do_op(w8, a, b, s, lat, hi, lo, exc, bok, pok);
      model(w8, a, b, s, ehi, elo, eexc);
      n_cmp++; if ({hi, lo, exc} !== {ehi, elo, eexc}) begin n_bad++;
        $display("FAIL rnd%0d_result got %h_%h exc=%0b expected %h_%h exc=%0b", i, hi, lo, exc, ehi, elo, eexc); end
      n_cmp++; if (lat != exp_lat(w8, b, s) || !bok || !pok) begin n_bad++;
        $display("FAIL rnd%0d_timing got lat=%0d busy_ok=%0b pulse_ok=%0b expected lat=%0d 1 1",
                 i, lat, bok, pok, exp_lat(w8, b, s)); end
    end
  endtask

  task automatic test_restart();
    int lat, pulses1, pulses2; logic [31:0] hi, lo; bit exc;
    pulses1 = 0; pulses2 = 0; lat = -1; hi = '0; lo = '0; exc = 1'b0;
    @(negedge clock); mult = 1'b1; sgn = 1'b0; a32 = 32'd5; b32 = 32'd9;
    @(posedge clock); #1; mult = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); #1;
      if (rdy32) pulses1++;
    end
    @(negedge clock); mult = 1'b1; a32 = 32'd3; b32 = 32'd4;
    @(posedge clock); #1; mult = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (rdy32) begin
        pulses2++;
        if (lat < 0) begin lat = n; hi = hi32; lo = lo32; exc = exc32; end
      end
    end
    $display("restart: pulses_before=%0d pulses_after=%0d lat=%0d hi=%h lo=%h exc=%0b",
             pulses1, pulses2, lat, hi, lo, exc);
    n_cmp++; if (pulses1 != ((exp_lat(1'b0, 32'd9, 1'b0) <= 5) ? 1 : 0) || pulses2 != 1) begin n_bad++;
      $display("FAIL restart_pulses got %0d/%0d expected %0d/1", pulses1, pulses2,
               (exp_lat(1'b0, 32'd9, 1'b0) <= 5) ? 1 : 0); end
    n_cmp++; if (lat != exp_lat(1'b0, 32'd4, 1'b0)) begin n_bad++;
      $display("FAIL restart_latency got %0d expected %0d", lat, exp_lat(1'b0, 32'd4, 1'b0)); end
    n_cmp++; if ({hi, lo, exc} !== {32'd0, 32'd12, 1'b0}) begin n_bad++;
      $display("FAIL restart_result got %h_%h exc=%0b expected 0_c exc=0", hi, lo, exc); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    @(negedge clock); mult = 1'b1; sgn = 1'b0; a32 = 32'h1234_5679; b32 = 32'h8765_4321;
    @(posedge clock); #1; mult = 1'b0;
    repeat (7) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    $display("reset mid-run: busy=%0b rdy=%0b hi=%h lo=%h exc=%0b", busy32, rdy32, hi32, lo32, exc32);
    n_cmp++; if ({busy32, rdy32, exc32, hi32, lo32} !== 67'd0) begin n_bad++;
      $display("FAIL reset_mid_outputs got %h expected 0", {busy32, rdy32, exc32, hi32, lo32}); end
    // Start and reset in the same cycle: reset must win.
    @(negedge clock); mult = 1'b1; a32 = 32'd3; b32 = 32'd5;
    @(posedge clock); #1;
    n_cmp++; if (busy32 !== 1'b0) begin n_bad++;
      $display("FAIL reset_vs_start got busy=%0b expected 0", busy32); end
    @(negedge clock); reset = 1'b0; mult = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clock); #1;
      if (rdy32 || busy32) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++;
      $display("FAIL reset_no_rdy got %0d active cycles expected 0", pulses); end
  endtask

  task automatic test_done_restart();
    int lat; logic [31:0] a1, b1, a2, b2, ehi, elo; bit s1, s2, eexc;
    a1 = pick(1'b0); b1 = pick(1'b0); s1 = 1'($urandom);
    a2 = $urandom; b2 = $urandom; s2 = 1'($urandom);
    @(negedge clock); mult = 1'b1; sgn = s1; a32 = a1; b32 = b1;
    @(posedge clock); #1; mult = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (rdy32) begin lat = n; break; end
    end
    // Now inside the ready cycle: request the next operation on its closing edge.
    mult = 1'b1; sgn = s2; a32 = a2; b32 = b2;
    model(1'b0, a1, b1, s1, ehi, elo, eexc);
    $display("done-restart first: a=%h b=%h s=%0b hi=%h lo=%h lat=%0d", a1, b1, s1, hi32, lo32, lat);
    n_cmp++; if (lat != exp_lat(1'b0, b1, s1) || {hi32, lo32, exc32} !== {ehi, elo, eexc}) begin n_bad++;
      $display("FAIL done_restart_first got lat=%0d %h_%h exc=%0b expected lat=%0d %h_%h exc=%0b",
               lat, hi32, lo32, exc32, exp_lat(1'b0, b1, s1), ehi, elo, eexc); end
    @(posedge clock); #1; mult = 1'b0;
    n_cmp++; if ({busy32, rdy32} !== 2'b10) begin n_bad++;
      $display("FAIL done_restart_load got busy/rdy=%b expected 10", {busy32, rdy32}); end
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (rdy32) begin lat = n; break; end
    end
    model(1'b0, a2, b2, s2, ehi, elo, eexc);
    $display("done-restart second: a=%h b=%h s=%0b hi=%h lo=%h lat=%0d", a2, b2, s2, hi32, lo32, lat);
    n_cmp++; if (lat != exp_lat(1'b0, b2, s2) || {hi32, lo32, exc32} !== {ehi, elo, eexc}) begin n_bad++;
      $display("FAIL done_restart_second got lat=%0d %h_%h exc=%0b expected lat=%0d %h_%h exc=%0b",
               lat, hi32, lo32, exc32, exp_lat(1'b0, b2, s2), ehi, elo, eexc); end
  endtask

  task automatic test_result_hold();
    int lat; logic [31:0] hi, lo, ehi, elo; bit exc, eexc, bok, pok;
    do_op(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, lat, hi, lo, exc, bok, pok);
    @(negedge clock); mult = 1'b1; sgn = 1'b0; a32 = 32'h0000_0003; b32 = 32'hF0F0_1234;
    @(posedge clock); #1; mult = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    $display("hold: busy=%0b hi=%h lo=%h", busy32, hi32, lo32);
    n_cmp++; if ({busy32, hi32, lo32} !== {1'b1, hi, lo}) begin n_bad++;
      $display("FAIL hold_during_run got busy=%0b %h_%h expected busy=1 %h_%h", busy32, hi32, lo32, hi, lo); end
    lat = -1;
    for (int n = 4; n <= 100; n++) begin
      @(posedge clock); #1;
      if (rdy32) begin lat = n; break; end
    end
    model(1'b0, 32'h3, 32'hF0F0_1234, 1'b0, ehi, elo, eexc);
    n_cmp++; if (lat != exp_lat(1'b0, 32'hF0F0_1234, 1'b0) || {hi32, lo32, exc32} !== {ehi, elo, eexc}) begin n_bad++;
      $display("FAIL hold_next_result got lat=%0d %h_%h exc=%0b expected lat=%0d %h_%h exc=%0b",
               lat, hi32, lo32, exc32, exp_lat(1'b0, 32'hF0F0_1234, 1'b0), ehi, elo, eexc); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_restart();
    test_reset_mid();
    test_done_restart();
    test_result_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
